// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Time-multiplexed common-anode 7-segment driver. Holds a
//                shadow copy of hex/point/blank/blink data, scans one digit
//                per SCAN_CYCLES clocks, encodes hex nibbles internally and
//                blinks selected digits with a frame-count derived phase.
//  Options     : define SEG7_LEADING_ZERO_BLANK_EN to darken leading zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int DIGITS         = 8,
  parameter int SCAN_CYCLES    = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int C_IDX_W  = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
  localparam int C_SCAN_W = (SCAN_CYCLES > 1)  ? $clog2(SCAN_CYCLES)  : 1;
  localparam int C_FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [C_IDX_W-1:0]  C_IDX_LAST  = C_IDX_W'(DIGITS - 1);
  localparam logic [C_SCAN_W-1:0] C_SCAN_LAST = C_SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [C_FRM_W-1:0]  C_FRM_LAST  = C_FRM_W'(BLINK_FRAMES - 1);
  localparam logic [7:0]          C_SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0]   C_AN_OFF    = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Scan / blink timing state
  logic [C_SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [C_IDX_W-1:0]  idx_q, idx_d;
  logic [C_FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic                phase_q, phase_d;
  logic                wrap_q, wrap_d;

  // Shadow display data
  logic [4*DIGITS-1:0] hexs_q, hexs_d;
  logic [DIGITS-1:0]   points_q, points_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   blink_q, blink_d;

  // Registered pin drivers
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;

  // Digits forced dark by leading-zero suppression (all clear when disabled)
  logic [DIGITS-1:0]   lz_dark;

  // Active-high g..a pattern for one hex nibble
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    case (nib)
      4'h0: hex_font = 7'h3F;
      4'h1: hex_font = 7'h06;
      4'h2: hex_font = 7'h5B;
      4'h3: hex_font = 7'h4F;
      4'h4: hex_font = 7'h66;
      4'h5: hex_font = 7'h6D;
      4'h6: hex_font = 7'h7D;
      4'h7: hex_font = 7'h07;
      4'h8: hex_font = 7'h7F;
      4'h9: hex_font = 7'h6F;
      4'hA: hex_font = 7'h77;
      4'hB: hex_font = 7'h7C;
      4'hC: hex_font = 7'h39;
      4'hD: hex_font = 7'h5E;
      4'hE: hex_font = 7'h79;
      4'hF: hex_font = 7'h71;
    endcase
  endfunction

  // Scan counter, digit index and blink phase advance
  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    wrap_d      = 1'b0;
    if (scan_cnt_q == C_SCAN_LAST) begin
      scan_cnt_d = '0;
      if (idx_q == C_IDX_LAST) begin
        idx_d  = '0;
        wrap_d = 1'b1;
        if (frame_cnt_q == C_FRM_LAST) begin
          frame_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Shadow capture; the latest load always wins
  always_comb begin
    hexs_d   = hexs_q;
    points_d = points_q;
    blank_d  = blank_q;
    blink_d  = blink_q;
    if (load) begin
      hexs_d   = hexs;
      points_d = points;
      blank_d  = blank;
      blink_d  = blink;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; stay dark while every digit so far is a bare zero
  always_comb begin
    logic still_zero;
    still_zero = 1'b1;
    lz_dark    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      still_zero = still_zero & (hexs_q[4*i +: 4] == 4'h0) & ~points_q[i];
      lz_dark[i] = still_zero;
    end
  end
`else
  assign lz_dark = '0;
`endif

  // Pin values for the selected digit, registered together so seg/an never skew
  always_comb begin
    logic [3:0]        nib;
    logic [7:0]        raw;
    logic              dark;
    logic [DIGITS-1:0] onehot;
    nib    = hexs_q[{idx_q, 2'b00} +: 4];
    dark   = blank_q[idx_q] | (blink_q[idx_q] & phase_q) | lz_dark[idx_q];
    raw    = dark ? 8'h00 : {points_q[idx_q], hex_font(nib)};
    onehot = '0;
    onehot[idx_q] = 1'b1;
    seg_d        = SEG_ACTIVE_LOW ? ~raw : raw;
    an_d         = AN_ACTIVE_LOW ? ~onehot : onehot;
    frame_done_d = wrap_q;
  end

  // State registers with synchronous reset overriding load
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
      wrap_q       <= 1'b0;
      hexs_q       <= '0;
      points_q     <= '0;
      blank_q      <= '0;
      blink_q      <= '0;
      seg_q        <= C_SEG_OFF;
      an_q         <= C_AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      wrap_q       <= wrap_d;
      hexs_q       <= hexs_d;
      points_q     <= points_d;
      blank_q      <= blank_d;
      blink_q      <= blink_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_ctrl
//  Description : Directed self-checking bench for seg7_scan_ctrl with
//                DIGITS=4, SCAN_CYCLES=4, BLINK_FRAMES=2, active-low pins.
//                Honours SEG7_LEADING_ZERO_BLANK_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  blank;
  logic [3:0]  blink;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int n_edge = 0;            // clk edges since reset was last released

  logic [7:0] exp_seg [4];   // expected visible pattern per digit
  logic [3:0] exp_blink;     // digits expected to vanish in blink phase 1

  seg7_scan_ctrl #(
    .DIGITS         (4),
    .SCAN_CYCLES    (4),
    .BLINK_FRAMES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .hexs       (hexs),
    .points     (points),
    .blank      (blank),
    .blink      (blink),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Edge counter used to place each cycle within the scan/blink schedule
  always @(posedge clk) begin
    if (rst) n_edge <= 0;
    else     n_edge <= n_edge + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", tag, obs, exp, n_edge, $time);
    end
  endtask

  task automatic set_exp(input logic [7:0] d3, input logic [7:0] d2,
                         input logic [7:0] d1, input logic [7:0] d0);
    exp_seg[3] = d3;
    exp_seg[2] = d2;
    exp_seg[1] = d1;
    exp_seg[0] = d0;
  endtask

  // Drive one load pulse starting at a falling edge; returns one falling edge later
  task automatic do_load(input logic [15:0] h, input logic [3:0] p,
                         input logic [3:0] bl, input logic [3:0] bk);
    hexs   = h;
    points = p;
    blank  = bl;
    blink  = bk;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Check seg/an/frame_done on each of k falling edges against the schedule
  task automatic run_cycles(input int k);
    int d, f, ph;
    logic [7:0] es;
    logic [3:0] ea;
    logic       ef;
    for (int c = 0; c < k; c++) begin
      @(negedge clk);
      if (n_edge == 0) begin
        es = 8'hFF; ea = 4'hF; ef = 1'b0;
      end else begin
        d  = ((n_edge - 1) / 4) % 4;
        f  = (n_edge - 1) / 16;
        ph = (f / 2) % 2;
        es = (exp_blink[d] && ph == 1) ? 8'hFF : exp_seg[d];
        ea = ~(4'b0001 << d);
        ef = (n_edge > 1) && ((n_edge - 1) % 16 == 0);
      end
      check_val("seg", {24'h0, seg}, {24'h0, es});
      check_val("an", {28'h0, an}, {28'h0, ea});
      check_val("frame_done", {31'h0, frame_done}, {31'h0, ef});
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1; load = 1'b0; hexs = '0; points = '0; blank = '0; blink = '0;
    set_exp(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    exp_blink = 4'b0000;

    // Reset held, load asserted alongside: reset values must win
    repeat (2) @(negedge clk);
    hexs = 16'hFFFF; points = 4'hF; load = 1'b1;
    run_cycles(2);

    // Release: digit 0 selected with empty shadow (0 -> C0)
    rst = 1'b0; load = 1'b0;
    run_cycles(4);

    // 12AF: digit0 F=8E, digit1 A=88, digit2 2=A4, digit3 1=F9
    do_load(16'h12AF, 4'b0000, 4'b0000, 4'b0000);
    set_exp(8'hF9, 8'hA4, 8'h88, 8'h8E);
    run_cycles(40);

    // Blink digit 0: two frames visible, two frames dark
    do_load(16'h12AF, 4'b0000, 4'b0000, 4'b0001);
    exp_blink = 4'b0001;
    run_cycles(70);

    // Blank digit 2 with its point set: whole digit dark
    do_load(16'h12AF, 4'b0100, 4'b0100, 4'b0000);
    exp_blink = 4'b0000;
    set_exp(8'hF9, 8'hFF, 8'h88, 8'h8E);
    run_cycles(16);

    // Align to the first cycle of digit 2's slot
    guard = 0;
    while (!(((n_edge - 1) / 4) % 4 == 2 && (n_edge - 1) % 4 == 0) && guard < 20) begin
      run_cycles(1);
      guard++;
    end
    if (guard >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL digit2_align: no digit-2 slot start seen within 20 cycles");
    end
    // Unblank mid-slot: old value at the load edge, new value one cycle later
    hexs = 16'h12AF; points = 4'b0100; blank = 4'b0000; blink = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_val("load_edge_seg", {24'h0, seg}, 32'h0000_00FF);
    check_val("load_edge_an", {28'h0, an}, 32'h0000_000B);
    @(negedge clk);
    check_val("load_next_seg", {24'h0, seg}, 32'h0000_0024);
    check_val("load_next_an", {28'h0, an}, 32'h0000_000B);
    set_exp(8'hF9, 8'h24, 8'h88, 8'h8E);
    run_cycles(16);

    // Leading zeros: 0050 then 0000
    do_load(16'h0050, 4'b0000, 4'b0000, 4'b0000);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    set_exp(8'hFF, 8'hFF, 8'h92, 8'hC0);
`else
    set_exp(8'hC0, 8'hC0, 8'h92, 8'hC0);
`endif
    run_cycles(16);
    do_load(16'h0000, 4'b0000, 4'b0000, 4'b0000);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    set_exp(8'hFF, 8'hFF, 8'hFF, 8'hC0);
`else
    set_exp(8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif
    run_cycles(16);

    // Mid-frame reset with load asserted: shadow cleared, scan restarts at digit 0
    do_load(16'h12AF, 4'b0000, 4'b0000, 4'b0000);
    set_exp(8'hF9, 8'hA4, 8'h88, 8'h8E);
    run_cycles(6);
    rst = 1'b1; load = 1'b1; hexs = 16'hFFFF; points = 4'hF; blank = 4'h0; blink = 4'hF;
    run_cycles(2);
    rst = 1'b0; load = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    set_exp(8'hFF, 8'hFF, 8'hFF, 8'hC0);
`else
    set_exp(8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif
    exp_blink = 4'b0000;
    run_cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
